// File: rtl/mining_engine.sv
// mining_engine: session control FSM, hashing timer and an iterative SHA-256d
// core that searches nonces for the lowest byte-reversed double hash.
// Build option: define MINING_MIDSTATE_EN to compress the nonce-independent
// first header block once per session and reuse its chaining value.
module mining_engine #(
  parameter int unsigned CLK_RATE   = 100_000_000,
  parameter int unsigned HASH_TICKS = 1
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         finished_recieving,
  input  logic         finished_sending,
  input  logic [607:0] block_without_nonce,
  input  logic [31:0]  nonce_base,
  output logic         read_enable,
  output logic         hash_enable,
  output logic         write_enable,
  output logic         second_tick,
  output logic [255:0] best_hash,
  output logic [31:0]  best_hash_nonce
);

  localparam logic [1:0] ST_READ  = 2'd0;
  localparam logic [1:0] ST_HASH  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  localparam logic [31:0] CLK_RATE_M1   = 32'(CLK_RATE - 32'd1);
  localparam logic [31:0] HASH_TICKS_M1 = 32'(HASH_TICKS - 32'd1);

  // Block the core restarts from for each new nonce.
`ifdef MINING_MIDSTATE_EN
  localparam logic [1:0] RESTART_BLK = 2'd1;
`else
  localparam logic [1:0] RESTART_BLK = 2'd0;
`endif

  // Compression cycle numbering: 0 load, 1..64 rounds, 65 feed-forward.
  localparam logic [6:0] CYC_LOAD     = 7'd0;
  localparam logic [6:0] CYC_LAST_RND = 7'd64;

  // ---------------------------------------------------------------- helpers
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Big-endian message word j built from header bytes 4j..4j+3.
  function automatic logic [31:0] hdr_word(input logic [607:0] hdr, input int j);
    return {hdr[32*j +: 8], hdr[32*j+8 +: 8], hdr[32*j+16 +: 8], hdr[32*j+24 +: 8]};
  endfunction

  function automatic logic [31:0] iv_word(input logic [2:0] i);
    logic [31:0] v;
    case (i)
      3'd0:    v = 32'h6a09e667;
      3'd1:    v = 32'hbb67ae85;
      3'd2:    v = 32'h3c6ef372;
      3'd3:    v = 32'ha54ff53a;
      3'd4:    v = 32'h510e527f;
      3'd5:    v = 32'h9b05688c;
      3'd6:    v = 32'h1f83d9ab;
      3'd7:    v = 32'h5be0cd19;
      default: v = 32'h00000000;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] k_const(input logic [5:0] t);
    logic [31:0] k;
    case (t)
      6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;  6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;  6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;  6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;  6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;  6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;  6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;  6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;  6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;  6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;  6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;  6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;  6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;  6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;  6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;  6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;  6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
      default: k = 32'h00000000;
    endcase
    return k;
  endfunction

  // ---------------------------------------------------------------- signals
  logic [1:0]   state_r;
  logic [1:0]   state_nxt_s;
  logic         hash_start_s;
  logic         tick_s;
  logic         last_tick_s;
  logic [31:0]  timer_cnt_r;
  logic [31:0]  tick_cnt_r;

  logic [607:0] hdr_r;
  logic [31:0]  nonce_r;
  logic         core_run_r;
  logic         cmp_r;
  logic [1:0]   blk_r;
  logic [6:0]   cyc_r;
  logic [31:0]  wk_r   [8];
  logic [31:0]  hin_r  [8];
  logic [31:0]  w_r    [16];
  logic [31:0]  mid_r  [8];
  logic [31:0]  dig1_r [8];
  logic [255:0] cand_r;
  logic [255:0] best_hash_r;
  logic [31:0]  best_nonce_r;

  logic [31:0]  msg_w_s [16];
  logic [31:0]  chain_s [8];
  logic [31:0]  ff_s    [8];
  logic [31:0]  t1_s;
  logic [31:0]  t2_s;
  logic [31:0]  w_new_s;
  logic [5:0]   rnd_s;
  logic [255:0] dig_s;
  logic [255:0] disp_s;

  // ---------------------------------------------------------------- control
  assign hash_start_s = (state_r == ST_READ) && finished_recieving;
  assign tick_s       = (state_r == ST_HASH) && (timer_cnt_r == CLK_RATE_M1);
  assign last_tick_s  = tick_s && (tick_cnt_r == HASH_TICKS_M1);

  assign read_enable     = (state_r == ST_READ);
  assign hash_enable     = (state_r == ST_HASH);
  assign write_enable    = (state_r == ST_WRITE);
  assign second_tick     = tick_s;
  assign best_hash       = best_hash_r;
  assign best_hash_nonce = best_nonce_r;

  // Next-state decode; handshakes outside their own state are ignored.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_READ:  if (finished_recieving) state_nxt_s = ST_HASH;  else state_nxt_s = ST_READ;
      ST_HASH:  if (last_tick_s)        state_nxt_s = ST_WRITE; else state_nxt_s = ST_HASH;
      ST_WRITE: if (finished_sending)   state_nxt_s = ST_READ;  else state_nxt_s = ST_WRITE;
      default:  state_nxt_s = ST_READ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst_i) state_r <= ST_READ;
    else       state_r <= state_nxt_s;
  end

  // Cycle counter producing second_tick; held at zero outside HASH.
  always_ff @(posedge clk) begin
    if (rst_i)                            timer_cnt_r <= 32'd0;
    else if (state_r != ST_HASH)          timer_cnt_r <= 32'd0;
    else if (timer_cnt_r == CLK_RATE_M1)  timer_cnt_r <= 32'd0;
    else                                  timer_cnt_r <= timer_cnt_r + 32'd1;
  end

  // Counts ticks seen in the current HASH session.
  always_ff @(posedge clk) begin
    if (rst_i)                   tick_cnt_r <= 32'd0;
    else if (state_r != ST_HASH) tick_cnt_r <= 32'd0;
    else if (tick_s)             tick_cnt_r <= tick_cnt_r + 32'd1;
    else                         tick_cnt_r <= tick_cnt_r;
  end

  // ---------------------------------------------------------------- datapath
  // Message block and chaining input for the block about to be loaded.
  always_comb begin
    for (int i = 0; i < 16; i++) msg_w_s[i] = 32'd0;
    for (int i = 0; i < 8; i++)  chain_s[i] = iv_word(3'(i));
    case (blk_r)
      2'd0: begin
        for (int i = 0; i < 16; i++) msg_w_s[i] = hdr_word(hdr_r, i);
      end
      2'd1: begin
        msg_w_s[0]  = hdr_word(hdr_r, 16);
        msg_w_s[1]  = hdr_word(hdr_r, 17);
        msg_w_s[2]  = hdr_word(hdr_r, 18);
        msg_w_s[3]  = {nonce_r[7:0], nonce_r[15:8], nonce_r[23:16], nonce_r[31:24]};
        msg_w_s[4]  = 32'h80000000;
        msg_w_s[15] = 32'd640;
        for (int i = 0; i < 8; i++) chain_s[i] = mid_r[i];
      end
      2'd2: begin
        for (int i = 0; i < 8; i++) msg_w_s[i] = dig1_r[i];
        msg_w_s[8]  = 32'h80000000;
        msg_w_s[15] = 32'd256;
      end
      default: begin
        msg_w_s[0] = 32'd0;
      end
    endcase
  end

  // One SHA-256 round plus the next schedule word from the 16-word window.
  always_comb begin
    rnd_s   = 6'(cyc_r - 7'd1);
    t1_s    = wk_r[7] + bsig1(wk_r[4]) + ch(wk_r[4], wk_r[5], wk_r[6]) + k_const(rnd_s) + w_r[0];
    t2_s    = bsig0(wk_r[0]) + maj(wk_r[0], wk_r[1], wk_r[2]);
    w_new_s = ssig1(w_r[14]) + w_r[9] + ssig0(w_r[1]) + w_r[0];
  end

  // Feed-forward sum and its byte-reversed (display) form.
  always_comb begin
    dig_s  = 256'd0;
    disp_s = 256'd0;
    for (int i = 0; i < 8; i++) begin
      ff_s[i] = hin_r[i] + wk_r[i];
      dig_s[255-32*i -: 32] = ff_s[i];
    end
    for (int i = 0; i < 32; i++) disp_s[8*i +: 8] = dig_s[255-8*i -: 8];
  end

  // Core sequencer: session latch, compressions, compare and nonce advance.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      hdr_r        <= 608'd0;
      nonce_r      <= 32'd0;
      core_run_r   <= 1'b0;
      cmp_r        <= 1'b0;
      blk_r        <= 2'd0;
      cyc_r        <= CYC_LOAD;
      cand_r       <= 256'd0;
      best_hash_r  <= {256{1'b1}};
      best_nonce_r <= 32'd0;
      for (int i = 0; i < 8; i++) begin
        wk_r[i]   <= 32'd0;
        hin_r[i]  <= 32'd0;
        mid_r[i]  <= 32'd0;
        dig1_r[i] <= 32'd0;
      end
      for (int i = 0; i < 16; i++) w_r[i] <= 32'd0;
    end else if (hash_start_s) begin
      hdr_r       <= block_without_nonce;
      nonce_r     <= nonce_base;
      best_hash_r <= {256{1'b1}};
      core_run_r  <= 1'b1;
      cmp_r       <= 1'b0;
      blk_r       <= 2'd0;
      cyc_r       <= CYC_LOAD;
    end else if (state_r != ST_HASH) begin
      // Outside HASH the core is parked; any partial work is dropped.
      core_run_r <= 1'b0;
      cmp_r      <= 1'b0;
      blk_r      <= 2'd0;
      cyc_r      <= CYC_LOAD;
    end else if (cmp_r) begin
      if (cand_r < best_hash_r) begin
        best_hash_r  <= cand_r;
        best_nonce_r <= nonce_r;
      end
      nonce_r    <= nonce_r + 32'd1;
      cmp_r      <= 1'b0;
      core_run_r <= 1'b1;
      blk_r      <= RESTART_BLK;
      cyc_r      <= CYC_LOAD;
    end else if (core_run_r) begin
      if (cyc_r == CYC_LOAD) begin
        for (int i = 0; i < 8; i++) begin
          wk_r[i]  <= chain_s[i];
          hin_r[i] <= chain_s[i];
        end
        for (int i = 0; i < 16; i++) w_r[i] <= msg_w_s[i];
        cyc_r <= cyc_r + 7'd1;
      end else if (cyc_r <= CYC_LAST_RND) begin
        wk_r[0] <= t1_s + t2_s;
        wk_r[1] <= wk_r[0];
        wk_r[2] <= wk_r[1];
        wk_r[3] <= wk_r[2];
        wk_r[4] <= wk_r[3] + t1_s;
        wk_r[5] <= wk_r[4];
        wk_r[6] <= wk_r[5];
        wk_r[7] <= wk_r[6];
        for (int i = 0; i < 15; i++) w_r[i] <= w_r[i+1];
        w_r[15] <= w_new_s;
        cyc_r   <= cyc_r + 7'd1;
      end else begin
        cyc_r <= CYC_LOAD;
        case (blk_r)
          2'd0: begin
            for (int i = 0; i < 8; i++) mid_r[i] <= ff_s[i];
            blk_r <= 2'd1;
          end
          2'd1: begin
            for (int i = 0; i < 8; i++) dig1_r[i] <= ff_s[i];
            blk_r <= 2'd2;
          end
          2'd2: begin
            cand_r     <= disp_s;
            core_run_r <= 1'b0;
            cmp_r      <= 1'b1;
          end
          default: begin
            blk_r <= 2'd0;
          end
        endcase
      end
    end else begin
      core_run_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mining_engine.sv
// Scoreboard bench for mining_engine: a byte-level SHA-256d model predicts the
// best hash/nonce of each session; a monitor checks results and session timing.
module tb_mining_engine;

  localparam int CLK_RATE   = 1000;
  localparam int HASH_TICKS = 2;
  localparam int T_HASH     = CLK_RATE * HASH_TICKS;
`ifdef MINING_MIDSTATE_EN
  localparam int SETUP  = 66;
  localparam int PERIOD = 133;
`else
  localparam int SETUP  = 0;
  localparam int PERIOD = 199;
`endif

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         finished_recieving = 1'b0;
  logic         finished_sending = 1'b0;
  logic [607:0] block_without_nonce = 608'd0;
  logic [31:0]  nonce_base = 32'd0;
  logic         read_enable, hash_enable, write_enable, second_tick;
  logic [255:0] best_hash;
  logic [31:0]  best_hash_nonce;

  mining_engine #(.CLK_RATE(CLK_RATE), .HASH_TICKS(HASH_TICKS)) dut (
    .clk(clk), .rst_i(rst_i),
    .finished_recieving(finished_recieving), .finished_sending(finished_sending),
    .block_without_nonce(block_without_nonce), .nonce_base(nonce_base),
    .read_enable(read_enable), .hash_enable(hash_enable), .write_enable(write_enable),
    .second_tick(second_tick), .best_hash(best_hash), .best_hash_nonce(best_hash_nonce)
  );

  always #5 clk = ~clk;

  typedef struct { logic [255:0] h; logic [31:0] n; } exp_t;
  exp_t sb_q[$];

  int vec_cnt  = 0;
  int miss_cnt = 0;
  logic [31:0] k_tab [64];
  logic [31:0] iv_tab [8];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ---- reference model: constants from prime roots, SHA-256 over byte strings
  function automatic logic [31:0] frac_root(input int p, input int deg);
    logic [127:0] target, x, cand, pw;
    target = 128'(p) << (32 * deg);
    x = 128'd0;
    for (int b = 40; b >= 0; b--) begin
      cand = x | (128'd1 << b);
      pw = (deg == 2) ? cand * cand : cand * cand * cand;
      if (pw <= target) x = cand;
    end
    return x[31:0];
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256(input logic [7:0] msg[$]);
    logic [31:0] h[8], w[64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    logic [63:0] bitlen;
    bitlen = 64'(msg.size()) * 64'd8;
    msg.push_back(8'h80);
    while (msg.size() % 64 != 56) msg.push_back(8'h00);
    for (int i = 7; i >= 0; i--) msg.push_back(bitlen[8*i +: 8]);
    for (int i = 0; i < 8; i++) h[i] = iv_tab[i];
    for (int blk = 0; blk < msg.size() / 64; blk++) begin
      for (int t = 0; t < 16; t++)
        w[t] = {msg[64*blk+4*t], msg[64*blk+4*t+1], msg[64*blk+4*t+2], msg[64*blk+4*t+3]};
      for (int t = 16; t < 64; t++)
        w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
             + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
      for (int t = 0; t < 64; t++) begin
        t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k_tab[t] + w[t];
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
    end
    return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
  endfunction

  // Double hash of header||LE nonce, returned with the byte order reversed.
  function automatic logic [255:0] sha256d_disp(input logic [607:0] hdr, input logic [31:0] nonce);
    logic [7:0] m[$];
    logic [255:0] d1, d2, disp;
    for (int i = 0; i < 76; i++) m.push_back(hdr[8*i +: 8]);
    for (int i = 0; i < 4; i++)  m.push_back(nonce[8*i +: 8]);
    d1 = sha256(m);
    m.delete();
    for (int i = 0; i < 32; i++) m.push_back(d1[255-8*i -: 8]);
    d2 = sha256(m);
    for (int i = 0; i < 32; i++) disp[8*i +: 8] = d2[255-8*i -: 8];
    return disp;
  endfunction

  // Best result over every nonce whose compare fits inside the HASH window.
  function automatic exp_t model_session(input logic [607:0] hdr, input logic [31:0] base);
    exp_t r;
    logic [255:0] d;
    int n_done;
    n_done = 0;
    while (SETUP + (n_done + 1) * PERIOD - 1 <= T_HASH - 1) n_done++;
    r.h = {256{1'b1}};
    r.n = 32'd0;
    for (int k = 0; k < n_done; k++) begin
      d = sha256d_disp(hdr, base + 32'(k));
      if (d < r.h) begin r.h = d; r.n = base + 32'(k); end
    end
    return r;
  endfunction

  function automatic logic [607:0] rand_header();
    logic [607:0] h;
    for (int i = 0; i < 19; i++) h[32*i +: 32] = $urandom;
    return h;
  endfunction

  // ---- monitor: session length, tick count and scoreboard result checks
  initial begin : monitor
    int hcyc, ticks;
    logic prev_hash, prev_write;
    exp_t e;
    hcyc = 0; ticks = 0; prev_hash = 1'b0; prev_write = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        prev_hash = 1'b0; prev_write = 1'b0;
      end else begin
        if (hash_enable && !prev_hash) begin hcyc = 0; ticks = 0; end
        if (hash_enable) hcyc++;
        if (second_tick) ticks++;
        if (write_enable && !prev_write) begin
          check("hash_cycles", 256'(hcyc), 256'(T_HASH));
          check("tick_count", 256'(ticks), 256'(HASH_TICKS));
          if (sb_q.size() == 0) begin
            vec_cnt++; miss_cnt++;
            $display("FAIL unexpected_result: got a result, want none pending");
          end else begin
            e = sb_q.pop_front();
            check("best_hash", best_hash, e.h);
            check("best_nonce", 256'(best_hash_nonce), 256'(e.n));
          end
        end
        prev_hash = hash_enable;
        prev_write = write_enable;
      end
    end
  end

  // ---- driver
  task automatic run_session(input logic [607:0] hdr, input logic [31:0] base, input bit genesis);
    exp_t e;
    int n;
    logic [255:0] gen_hash;
    gen_hash = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
    e = model_session(hdr, base);
    sb_q.push_back(e);
    @(negedge clk);
    block_without_nonce = hdr; nonce_base = base; finished_recieving = 1'b1;
    @(negedge clk);
    finished_recieving = 1'b0;
    check("enter_hash", 256'(hash_enable), 256'd1);
    check("best_cleared", best_hash, {256{1'b1}});
    block_without_nonce = rand_header(); nonce_base = $urandom;
    repeat (700) @(negedge clk);
    finished_sending = 1'b1;
    @(negedge clk);
    finished_sending = 1'b0;
    check("ignore_send_in_hash", 256'(hash_enable), 256'd1);
    n = 0;
    while (!write_enable && n < 3000) begin @(negedge clk); n++; end
    check("write_reached", 256'(write_enable), 256'd1);
    finished_recieving = 1'b1;
    @(negedge clk);
    finished_recieving = 1'b0;
    check("ignore_recv_in_write", 256'(write_enable), 256'd1);
    repeat (20) @(negedge clk);
    check("best_frozen", best_hash, e.h);
    if (genesis) begin
      check("genesis_hash", best_hash, gen_hash);
      check("genesis_nonce", 256'(best_hash_nonce), 256'h7C2BAC1D);
    end
    finished_sending = 1'b1;
    @(negedge clk);
    finished_sending = 1'b0;
    check("back_to_read", 256'(read_enable), 256'd1);
  endtask

  initial begin : driver
    logic [607:0] gen_lit, gen_hdr;
    int primes[64];
    int cnt;
    int read_cycles;
    bit isp;
    cnt = 0;
    for (int n = 2; cnt < 64; n++) begin
      isp = 1'b1;
      for (int d = 2; d * d <= n; d++) if (n % d == 0) isp = 1'b0;
      if (isp) begin primes[cnt] = n; cnt++; end
    end
    for (int i = 0; i < 64; i++) k_tab[i] = frac_root(primes[i], 3);
    for (int i = 0; i < 8; i++)  iv_tab[i] = frac_root(primes[i], 2);

    gen_lit = 608'h01000000_0000000000000000_0000000000000000_0000000000000000_0000000000000000_3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a_29ab5f49_ffff001d;
    for (int i = 0; i < 76; i++) gen_hdr[8*i +: 8] = gen_lit[607-8*i -: 8];

    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_read", 256'(read_enable), 256'd1);
    check("rst_hash", 256'(hash_enable), 256'd0);
    check("rst_write", 256'(write_enable), 256'd0);
    check("rst_tick", 256'(second_tick), 256'd0);
    check("rst_best_hash", best_hash, {256{1'b1}});
    check("rst_best_nonce", 256'(best_hash_nonce), 256'd0);

    read_cycles = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (read_enable && !hash_enable && !write_enable) read_cycles++;
    end
    check("idle_stays_read", 256'(read_cycles), 256'd1000);

    run_session(gen_hdr, 32'h7C2BAC1A, 1'b1);
    run_session(gen_hdr, 32'h7C2BAC1D, 1'b1);
    run_session(rand_header(), $urandom, 1'b0);
    run_session(rand_header(), 32'hFFFFFFFE, 1'b0);

    // Reset in the middle of a compression.
    @(negedge clk);
    block_without_nonce = rand_header(); nonce_base = $urandom; finished_recieving = 1'b1;
    @(negedge clk);
    finished_recieving = 1'b0;
    repeat (500) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    check("midrst_read", 256'(read_enable), 256'd1);
    check("midrst_hash", 256'(hash_enable), 256'd0);
    check("midrst_write", 256'(write_enable), 256'd0);
    check("midrst_tick", 256'(second_tick), 256'd0);
    check("midrst_best_hash", best_hash, {256{1'b1}});
    check("midrst_best_nonce", 256'(best_hash_nonce), 256'd0);
    rst_i = 1'b0;
    repeat (5) @(negedge clk);

    run_session(rand_header(), $urandom, 1'b0);

    check("scoreboard_drained", 256'(sb_q.size()), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
